spislave_le: RTL

- SPI responder (slave) for the CPU-side SPI master on the same bus: same mode, same byte-swapped little-endian 16-bit word format.
- Lets a second J1a/iCE40 node, or a test fixture, answer an spimaster_le-style initiator.
- Memory-mapped I/O register block: CPU preloads a response word and reads back the received word plus the byte count.
- External SCL/MOSI/SS_N are asynchronous; everything is oversampled on clk.

---
 rtl/spislave_le.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/spislave_le.sv
// spislave_le: SPI responder (CPOL=0, CPHA=0) for byte-swapped little-endian
// 16-bit words. SCL, MOSI and SS_N are oversampled on clk through SYNC_STAGES
// synchronizer flops. The CPU preloads the response word with we/tx and reads
// back rx/rx_bytes when rx_valid pulses.
// Optional build macro SPISLAVE_OVERRUN_EN adds the rd_ack input and the
// overrun output.
module spislave_le #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [15:0] tx,
  output logic [15:0] rx,
  output logic [1:0]  rx_bytes,
  output logic        rx_valid,
  output logic        running,
  input  logic        SCL,
  input  logic        MOSI,
  input  logic        SS_N,
  output logic        MISO,
  output logic        MISO_OE
`ifdef SPISLAVE_OVERRUN_EN
  ,
  input  logic        rd_ack,
  output logic        overrun
`endif
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] scl_sync_reg, mosi_sync_reg, ss_sync_reg;
  logic                   scl_d_reg, ss_d_reg;
  logic                   s_scl, s_mosi, s_ss;
  logic                   scl_rise, scl_fall, ss_rise, ss_fall;

  logic [15:0] txbuf_reg;
  logic [15:0] shin_reg;
  // Bits still to be shifted out; the bit currently on the pin lives in MISO.
  logic [14:0] shout_reg;
  logic [4:0]  bitcnt_reg;

  logic [7:0]  first_byte_cand [8];
  logic [15:0] done_word;
  logic [1:0]  done_bytes;

  // Synchronizer chains plus one extra flop on SCL/SS_N for edge detection;
  // SS_N resets to its idle level so leaving reset never looks like a select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_reg  <= '0;
      mosi_sync_reg <= '0;
      ss_sync_reg   <= '1;
      scl_d_reg     <= 1'b0;
      ss_d_reg      <= 1'b1;
    end else begin
      scl_sync_reg  <= {scl_sync_reg[SYNC_STAGES-2:0], SCL};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], MOSI};
      ss_sync_reg   <= {ss_sync_reg[SYNC_STAGES-2:0], SS_N};
      scl_d_reg     <= s_scl;
      ss_d_reg      <= s_ss;
    end
  end

  assign s_scl    = scl_sync_reg[SYNC_STAGES-1];
  assign s_mosi   = mosi_sync_reg[SYNC_STAGES-1];
  assign s_ss     = ss_sync_reg[SYNC_STAGES-1];
  assign scl_rise = s_scl & ~scl_d_reg;
  assign scl_fall = ~s_scl & scl_d_reg;
  assign ss_rise  = s_ss & ~ss_d_reg;
  assign ss_fall  = ~s_ss & ss_d_reg;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state: select low starts a frame, select high ends it, DONE lasts one cycle.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (ss_fall) state_next = ACTIVE;
      ACTIVE:  if (ss_rise) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // With bitcnt = 8+k, the first complete byte sits at shin[bitcnt-1 -: 8].
  generate
    for (genvar gi = 8; gi < 16; gi++) begin : g_first_byte
      assign first_byte_cand[gi-8] = shin_reg[gi-1 -: 8];
    end
  endgenerate

  // Result of the frame as latched in the DONE cycle.
  always_comb begin
    done_word  = rx;
    done_bytes = 2'd0;
    if (bitcnt_reg == 5'd16) begin
      done_word  = {shin_reg[7:0], shin_reg[15:8]};
      done_bytes = 2'd2;
    end else if (bitcnt_reg >= 5'd8) begin
      done_word  = {8'h00, first_byte_cand[bitcnt_reg[2:0]]};
      done_bytes = 2'd1;
    end
  end

  // Datapath: response buffer, shift registers, bit counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txbuf_reg  <= '0;
      shin_reg   <= '0;
      shout_reg  <= '0;
      bitcnt_reg <= '0;
      MISO       <= 1'b0;
      rx         <= '0;
      rx_bytes   <= '0;
      rx_valid   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      // Byte swap so the low byte of tx is shifted out first.
      if (we) txbuf_reg <= {tx[7:0], tx[15:8]};
      unique case (state_reg)
        IDLE: begin
          if (ss_fall) begin
            shout_reg  <= txbuf_reg[14:0];
            MISO       <= txbuf_reg[15];
            bitcnt_reg <= '0;
          end
        end
        ACTIVE: begin
          if (scl_rise) begin
            shin_reg <= {shin_reg[14:0], s_mosi};
            if (bitcnt_reg != 5'd16) bitcnt_reg <= bitcnt_reg + 5'd1;
          end
          if (scl_fall) begin
            MISO      <= shout_reg[14];
            shout_reg <= {shout_reg[13:0], 1'b0};
          end
        end
        DONE: begin
          rx       <= done_word;
          rx_bytes <= done_bytes;
          rx_valid <= (done_bytes != 2'd0);
        end
        default: ;
      endcase
    end
  end

  assign running = (state_reg == ACTIVE);
  assign MISO_OE = running;

`ifdef SPISLAVE_OVERRUN_EN
  logic pending_reg;

  // Track an unacknowledged result; a new result on top of it flags overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (state_reg == DONE && done_bytes != 2'd0) begin
        pending_reg <= 1'b1;
        if (pending_reg && !rd_ack) overrun <= 1'b1;
        else if (rd_ack)            overrun <= 1'b0;
      end else if (rd_ack) begin
        pending_reg <= 1'b0;
        overrun     <= 1'b0;
      end
    end
  end
`endif

endmodule
